bcd_scroll_window: RTL and testbench

Parametrised BCD display window with leading-digit detection, manual scroll and timed auto-scroll. The block captures a wide packed-BCD result from the arithmetic path and scans it sequentially to find the most significant non-zero digit. It then presents a DIGITS_OUT-digit window to the seven-segment driver. The window slides under button pulses or a free-running scroll timer, which replaces the fixed count-indexed window selection in the output unit.

---
 rtl/bcd_scroll_window.sv | 144 ++++++++++++++
 tb/tb_bcd_scroll_window.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scroll_window.sv
// rtl/bcd_scroll_window.sv - BCD display window with leading-digit scan, manual and timed scroll
// Captures a packed BCD value, finds its most significant non-zero digit, and slides a display window.
module bcd_scroll_window #(
  parameter int DIGITS_IN  = 11,
  parameter int DIGITS_OUT = 6,
  parameter int TICK_DIV   = 50_000_000,
  parameter int BLANK_LZ   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [4*DIGITS_IN-1:0]        bcd_in,
  input  logic                          scroll_left,
  input  logic                          scroll_right,
  input  logic                          auto_en,
  output logic [4*DIGITS_OUT-1:0]       bcd_out,
  output logic [$clog2(DIGITS_IN)-1:0]  offset,
  output logic                          busy,
  output logic                          at_min,
  output logic                          at_max
);

  localparam int IW = $clog2(DIGITS_IN);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [3:0] BLANK = (BLANK_LZ != 0) ? 4'hF : 4'h0;
  localparam logic [4*DIGITS_OUT-1:0] RESET_OUT = {{(DIGITS_OUT-1){BLANK}}, 4'h0};

  typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;

  state_t                   state, state_nxt;
  logic [4*DIGITS_IN-1:0]   val;
  logic [3:0]               dig [DIGITS_IN];
  logic [IW-1:0]            scan_idx;
  logic [IW-1:0]            msd;
  logic [IW-1:0]            max_off;
  logic [IW-1:0]            offset_nxt;
  logic [TW-1:0]            tick, tick_nxt;
  logic [IW:0]              widx;
  logic [4*DIGITS_OUT-1:0]  win_nxt;

  for (genvar g = 0; g < DIGITS_IN; g++) begin : g_dig
    assign dig[g] = val[4*g +: 4];
  end

  assign busy   = (state == SCAN);
  assign at_min = (offset == '0);
  assign at_max = (offset == max_off);

  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    tick_nxt   = tick;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt  = SCAN;
          offset_nxt = '0;
          tick_nxt   = '0;
        end else if (scroll_left ^ scroll_right) begin
          // A manual pulse overrides the timer and restarts its period
          if (scroll_left && offset < max_off)
            offset_nxt = offset + IW'(1);
          else if (scroll_right && offset != '0)
            offset_nxt = offset - IW'(1);
          tick_nxt = '0;
        end else if (auto_en && max_off != '0) begin
          if (tick == TICK_MAX) begin
            tick_nxt   = '0;
            offset_nxt = (offset == max_off) ? '0 : offset + IW'(1);
          end else begin
            tick_nxt = tick + TW'(1);
          end
        end else begin
          tick_nxt = '0;
        end
      end
      SCAN: begin
        tick_nxt = '0;
        if (load) begin
          state_nxt  = SCAN;
          offset_nxt = '0;
        end else if (scan_idx == IW'(1)) begin
          state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        tick_nxt = '0;
        if (load) begin
          state_nxt  = SCAN;
          offset_nxt = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window is built from the next-state offset so the display tracks a scroll on the same edge
  always_comb begin
    win_nxt = '0;
    widx    = '0;
    for (int k = 0; k < DIGITS_OUT; k++) begin
      widx = {1'b0, offset_nxt} + (IW+1)'(k);
      if (widx >= (IW+1)'(DIGITS_IN) || widx > {1'b0, msd})
        win_nxt[4*k +: 4] = BLANK;
      else
        win_nxt[4*k +: 4] = dig[widx[IW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      val      <= '0;
      scan_idx <= '0;
      msd      <= '0;
      max_off  <= '0;
      offset   <= '0;
      tick     <= '0;
      bcd_out  <= RESET_OUT;
    end else begin
      state  <= state_nxt;
      offset <= offset_nxt;
      tick   <= tick_nxt;
      if (load) begin
        val      <= bcd_in;
        scan_idx <= IW'(DIGITS_IN - 1);
        msd      <= '0;
      end else if (state == SCAN) begin
        // Scan runs downward, so msd==0 means nothing non-zero has been seen yet
        if (msd == '0 && dig[scan_idx] != 4'h0)
          msd <= scan_idx;
        scan_idx <= scan_idx - IW'(1);
      end else if (state == UPDATE) begin
        max_off <= (msd >= IW'(DIGITS_OUT)) ? msd - IW'(DIGITS_OUT - 1) : '0;
      end
      if (!load && state != SCAN)
        bcd_out <= win_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_scroll_window.sv
// tb/tb_bcd_scroll_window.sv - self-checking bench for bcd_scroll_window
// Behavioural model plus directed literal checks at the documented timing points.
module tb_bcd_scroll_window;

  localparam int DI = 11;
  localparam int DO = 6;
  localparam int TD = 4;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic [43:0]   bcd_in;
  logic          scroll_left;
  logic          scroll_right;
  logic          auto_en;
  logic [23:0]   bcd_out;
  logic [3:0]    offset;
  logic          busy;
  logic          at_min;
  logic          at_max;

  int n_chk;
  int n_fail;
  int bc;

  // model state
  logic [43:0] m_val;
  int          m_dig [DI];
  int          m_msd, m_max, m_off, m_tick, m_cnt;
  logic [23:0] m_out;

  bcd_scroll_window #(
    .DIGITS_IN(DI), .DIGITS_OUT(DO), .TICK_DIV(TD), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in),
    .scroll_left(scroll_left), .scroll_right(scroll_right), .auto_en(auto_en),
    .bcd_out(bcd_out), .offset(offset), .busy(busy), .at_min(at_min), .at_max(at_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] win(input int off);
    logic [23:0] r;
    int i;
    r = '0;
    for (int k = 0; k < DO; k++) begin
      i = off + k;
      if (i > m_msd) r[4*k +: 4] = 4'hF;
      else           r[4*k +: 4] = 4'(m_dig[i]);
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val = '0;
      for (int i = 0; i < DI; i++) m_dig[i] = 0;
      m_msd = 0; m_max = 0; m_off = 0; m_tick = 0; m_cnt = 0;
      m_out = 24'hFFFFF0;
    end else if (load) begin
      m_val = bcd_in;
      for (int i = 0; i < DI; i++) m_dig[i] = int'(m_val[4*i +: 4]);
      m_cnt = DI; m_off = 0; m_tick = 0;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_msd = 0;
        for (int i = 1; i < DI; i++) if (m_dig[i] != 0) m_msd = i;
        m_max = (m_msd >= DO) ? m_msd - DO + 1 : 0;
        m_out = win(m_off);
      end
    end else begin
      if (scroll_left ^ scroll_right) begin
        if (scroll_left) m_off = (m_off + 1 > m_max) ? m_max : m_off + 1;
        else             m_off = (m_off == 0) ? 0 : m_off - 1;
        m_tick = 0;
      end else if (auto_en && m_max > 0) begin
        m_tick = m_tick + 1;
        if (m_tick == TD) begin
          m_tick = 0;
          m_off = (m_off == m_max) ? 0 : m_off + 1;
        end
      end else begin
        m_tick = 0;
      end
      m_out = win(m_off);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [43:0] v);
    bcd_in = v;
    load = 1'b1;
    tick_n(1);
    load = 1'b0;
  endtask

  task automatic pulse(input logic l, input logic r);
    scroll_left = l;
    scroll_right = r;
    tick_n(1);
    scroll_left = 1'b0;
    scroll_right = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; load = 1'b0; bcd_in = '0;
    scroll_left = 1'b0; scroll_right = 1'b0; auto_en = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          chk("model_bcd_out", {8'h0, bcd_out}, {8'h0, m_out});
          chk("model_offset", {28'h0, offset}, m_off);
          chk("model_busy", {31'h0, busy}, {31'h0, m_cnt >= 2});
          chk("model_at_min", {31'h0, at_min}, {31'h0, m_off == 0});
          chk("model_at_max", {31'h0, at_max}, {31'h0, m_off == m_max});
        end
      end
    join_none

    tick_n(2);
    rst_n = 1'b1;
    tick_n(1);
    chk("reset_bcd_out", {8'h0, bcd_out}, 32'hFFFFF0);
    chk("reset_offset", {28'h0, offset}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_at_min", {31'h0, at_min}, 32'h1);
    chk("reset_at_max", {31'h0, at_max}, 32'h1);

    // short value: 10 busy cycles, display at load+12
    do_load(44'h000_0001_2345);
    bc = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) bc++;
      tick_n(1);
    end
    chk("short_busy_cycles", bc, 10);
    chk("short_busy_end", {31'h0, busy}, 32'h0);
    chk("short_hold_old", {8'h0, bcd_out}, 32'hFFFFF0);
    tick_n(1);
    chk("short_bcd_out", {8'h0, bcd_out}, 32'hF12345);
    chk("short_at_max", {31'h0, at_max}, 32'h1);
    pulse(1'b1, 1'b0);
    chk("short_left_offset", {28'h0, offset}, 32'h0);

    // full value, manual scroll
    do_load(44'h123_4567_8901);
    tick_n(11);
    chk("full_bcd_out", {8'h0, bcd_out}, 32'h678901);
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
    chk("full_off5", {28'h0, offset}, 32'h5);
    chk("full_bcd_off5", {8'h0, bcd_out}, 32'h123456);
    chk("full_at_max", {31'h0, at_max}, 32'h1);
    pulse(1'b1, 1'b0);
    chk("full_sixth_left", {28'h0, offset}, 32'h5);
    pulse(1'b0, 1'b1);
    chk("full_right_bcd", {8'h0, bcd_out}, 32'h234567);
    chk("full_right_off", {28'h0, offset}, 32'h4);

    // auto-scroll from a fresh load
    auto_en = 1'b1;
    do_load(44'h123_4567_8901);
    tick_n(11);
    for (int i = 1; i <= 9; i++) begin
      tick_n(TD);
      chk("auto_step", {28'h0, offset}, i % 6);
    end
    chk("auto_bcd_off3", {8'h0, bcd_out}, 32'h345678);
    tick_n(2);
    pulse(1'b0, 1'b1);
    chk("auto_right_off", {28'h0, offset}, 32'h2);
    tick_n(3);
    chk("auto_cnt_cleared", {28'h0, offset}, 32'h2);
    tick_n(1);
    chk("auto_after_clear", {28'h0, offset}, 32'h3);
    auto_en = 1'b0;

    // simultaneous pulses ignored
    pulse(1'b0, 1'b1);
    chk("simul_pre", {28'h0, offset}, 32'h2);
    pulse(1'b1, 1'b1);
    chk("simul_off", {28'h0, offset}, 32'h2);
    chk("simul_bcd", {8'h0, bcd_out}, 32'h456789);

    // load mid-scan restarts
    do_load(44'h123_4567_8901);
    tick_n(2);
    do_load(44'h000_0000_0007);
    tick_n(9);
    chk("midscan_busy", {31'h0, busy}, 32'h1);
    tick_n(1);
    chk("midscan_busy_end", {31'h0, busy}, 32'h0);
    chk("midscan_hold", {8'h0, bcd_out}, 32'h456789);
    tick_n(1);
    chk("midscan_bcd", {8'h0, bcd_out}, 32'hFFFFF7);

    // asynchronous reset during scan
    do_load(44'h123_4567_8901);
    tick_n(3);
    rst_n = 1'b0;
    #1;
    chk("arst_bcd_out", {8'h0, bcd_out}, 32'hFFFFF0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_at_max", {31'h0, at_max}, 32'h1);
    tick_n(2);
    rst_n = 1'b1;
    tick_n(1);
    do_load(44'h123_4567_8901);
    tick_n(11);
    chk("arst_reload_bcd", {8'h0, bcd_out}, 32'h678901);
    tick_n(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
